pipe_stage6_feeder: RTL
=======================

# pipe_stage6_feeder

Operand sequencer feeding the stage-6 pipeline. It captures one job's per-lane scalar operands, then streams vector tiles from the upstream tile buffer one beat per accepted transfer. Each beat is tagged with the stage index derived from a 16-bit beat counter and the job's stage boundaries. It is the producer end of the stage-6 operand interface (operandv/operand1..4/stage_boundary) and signals job completion back to the controller.

## Interface
- WIDTH, 16, fp16 element width
- PARALLEL, 3, number of lanes
- TILE, 128, elements per lane per vector beat
- PARA, 16, beat counter / boundary width
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- start_i  in  1  starts a job; sampled only in IDLE
- clear_i  in  1  synchronous abort to IDLE; highest priority after reset
- boundary_i  in  4×PARA  stage boundaries b0..b3, captured at start
- scal_valid_i  in  1  scalar set valid
- scal_ready_o  out  1  scalar set accepted
- scal_data_i  in  4×PARALLEL×WIDTH  operand1..4 per lane
- vec_valid_i  in  1  upstream vector beat valid
- vec_ready_o  out  1  vector beat accepted
- vec_data_i  in  PARALLEL×TILE×WIDTH  vector beat
- out_valid_o  out  1  beat valid to stage 6
- operandv_o  out  PARALLEL×TILE×WIDTH  vector operand
- operand1_o..operand4_o  out  PARALLEL×WIDTH each  scalar operands
- stage_boundary_o  out  4×PARA  captured boundaries
- stage_o  out  3  stage tag of current out beat, 0..3
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: on start_i, capture boundary_i into stage_boundary_o and go to LOAD.
- LOAD: scal_ready_o=1. On scal_valid_i, register scal_data_i into operand1..4_o and clear the beat counter. Next state is STREAM, or DONE if b3==0.
- STREAM: vec_ready_o=1. Each vec_valid_i cycle is one accepted beat:
  - operandv_o ← vec_data_i;
  - stage_o ← stage(cnt): 0 if cnt<b0, 1 if cnt<b1, 2 if cnt<b2, else 3;
  - out_valid_o ← 1 for the next cycle; cnt increments.
- When the beat with cnt==b3−1 is accepted, go to DONE. Exactly b3 beats are issued.
- Cycles with no valid beat: out_valid_o=0; operandv_o and stage_o hold.
- DONE: done_o=1 for one cycle, then IDLE. Operand and boundary registers hold until the next job.
- Boundaries: b0≤b1≤b2≤b3 is required. Equal boundaries make the stage between them empty, and that stage is skipped with no bubble. b3 below 2^PARA means the counter never wraps. Behaviour for non-monotone boundaries is undefined; stage_o simply follows the compare chain.
- Operand registers are written only in LOAD, so operands are constant for the whole stream.
- start_i outside IDLE is ignored.
- clear_i in any state: next state IDLE; out_valid_o, done_o, vec_ready_o and scal_ready_o go to 0 next cycle; cnt is cleared; a beat presented in the same cycle is not accepted.
- Reset values: state IDLE, cnt 0, all data outputs 0, stage_o 0, out_valid_o 0, done_o 0, busy_o 0, ready outputs 0.

## Timing
- vec_ready_o and scal_ready_o are combinational from state only, never from valid inputs.
- Beat latency is 1: a beat accepted at edge N appears on operandv_o with out_valid_o=1 during cycle N+1.
- Throughput is one beat per cycle.
- The last beat's out_valid_o and done_o are asserted in the same cycle.
- Scalar path: acceptance at edge N puts operands on the outputs from N+1. The first beat can be accepted in that same cycle.
- Async reset asserts immediately. Deassertion is synchronised externally. Reset during STREAM drops the job with no done_o.

## Test plan
- Boundaries {2,4,6,8}, scalars 0x3C00/0x4000/0x4200/0x4400 on all lanes, 8 back-to-back beats → out_valid_o high for 8 cycles, stage_o 0,0,1,1,2,2,3,3, done_o with beat 8, then IDLE.
- Same job with vec_valid_i toggling 1,0,1,0 → 8 beats spread over 15 cycles, stage tags unchanged, outputs held during gaps.
- Boundaries {0,0,3,3} → 3 beats, all stage_o=2; stages 0, 1 and 3 absent.
- b3=0 → LOAD→DONE, done_o pulse, zero out_valid_o, vec_ready_o never asserted.
- clear_i asserted after beat 3 of 8 → IDLE next cycle, no done_o. A new start with {1,1,1,2} gives stage_o 0,3 and counting restarts from 0.
- rst_ni pulled low mid-STREAM asynchronously → all outputs zero before the next edge; start_i in a non-IDLE state is ignored.

Source files
------------

// File: rtl/pipe_stage6_feeder.sv
// Stage-6 operand feeder: captures a job's boundaries and per-lane scalars, then
// streams vector tiles one beat per accepted transfer, tagging each beat with its stage.

module pipe_stage6_feeder_lane #(
    parameter int WIDTH = 16,
    parameter int TILE  = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ld_en,
    input  logic                       beat_en,
    input  logic [3:0][WIDTH-1:0]      scal_d,
    input  logic [TILE-1:0][WIDTH-1:0] vec_d,
    output logic [3:0][WIDTH-1:0]      scal_q,
    output logic [TILE-1:0][WIDTH-1:0] vec_q
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scal_q <= '0;
            vec_q  <= '0;
        end else begin
            if (ld_en)   scal_q <= scal_d;
            if (beat_en) vec_q  <= vec_d;
        end
    end
endmodule

module pipe_stage6_feeder #(
    parameter int WIDTH    = 16,
    parameter int PARALLEL = 3,
    parameter int TILE     = 128,
    parameter int PARA     = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     start_i,
    input  logic                                     clear_i,
    input  logic [3:0][PARA-1:0]                     boundary_i,
    input  logic                                     scal_valid_i,
    output logic                                     scal_ready_o,
    // index 0..3 selects operand1..operand4
    input  logic [3:0][PARALLEL-1:0][WIDTH-1:0]      scal_data_i,
    input  logic                                     vec_valid_i,
    output logic                                     vec_ready_o,
    input  logic [PARALLEL-1:0][TILE-1:0][WIDTH-1:0] vec_data_i,
    output logic                                     out_valid_o,
    output logic [PARALLEL-1:0][TILE-1:0][WIDTH-1:0] operandv_o,
    output logic [PARALLEL-1:0][WIDTH-1:0]           operand1_o,
    output logic [PARALLEL-1:0][WIDTH-1:0]           operand2_o,
    output logic [PARALLEL-1:0][WIDTH-1:0]           operand3_o,
    output logic [PARALLEL-1:0][WIDTH-1:0]           operand4_o,
    output logic [3:0][PARA-1:0]                     stage_boundary_o,
    output logic [2:0]                               stage_o,
    output logic                                     busy_o,
    output logic                                     done_o
);
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] stage;
    } beat_tag_t;

    state_t              state_q, state_d;
    logic [PARA-1:0]     cnt_q;
    logic [3:0][PARA-1:0] bnd_q;
    beat_tag_t           tag_q;
    logic                start_acc, scal_acc, beat_acc, last_beat;
    logic [2:0]          stage_nx;

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        scal_acc  = 1'b0;
        beat_acc  = 1'b0;
        last_beat = (cnt_q + PARA'(1)) == bnd_q[3];
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = LOAD;
                end
                LOAD: if (scal_valid_i) begin
                    scal_acc = 1'b1;
                    state_d  = (bnd_q[3] == '0) ? DONE : STREAM;
                end
                STREAM: if (vec_valid_i) begin
                    beat_acc = 1'b1;
                    if (last_beat) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Priority chain: with equal boundaries the empty stage is skipped naturally.
    always_comb begin
        if (cnt_q < bnd_q[0])      stage_nx = 3'd0;
        else if (cnt_q < bnd_q[1]) stage_nx = 3'd1;
        else if (cnt_q < bnd_q[2]) stage_nx = 3'd2;
        else                       stage_nx = 3'd3;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bnd_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q   <= state_d;
            tag_q.vld <= beat_acc;
            if (beat_acc)  tag_q.stage <= stage_nx;
            if (start_acc) bnd_q <= boundary_i;
            if (clear_i || scal_acc) cnt_q <= '0;
            else if (beat_acc)       cnt_q <= cnt_q + PARA'(1);
        end
    end

    assign scal_ready_o     = (state_q == LOAD);
    assign vec_ready_o      = (state_q == STREAM);
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign out_valid_o      = tag_q.vld;
    assign stage_o          = tag_q.stage;
    assign stage_boundary_o = bnd_q;

    for (genvar l = 0; l < PARALLEL; l++) begin : g_lane
        logic [3:0][WIDTH-1:0] lane_scal_d, lane_scal_q;

        for (genvar j = 0; j < 4; j++) begin : g_op
            assign lane_scal_d[j] = scal_data_i[j][l];
        end

        pipe_stage6_feeder_lane #(.WIDTH(WIDTH), .TILE(TILE)) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .ld_en   (scal_acc),
            .beat_en (beat_acc),
            .scal_d  (lane_scal_d),
            .vec_d   (vec_data_i[l]),
            .scal_q  (lane_scal_q),
            .vec_q   (operandv_o[l])
        );

        assign operand1_o[l] = lane_scal_q[0];
        assign operand2_o[l] = lane_scal_q[1];
        assign operand3_o[l] = lane_scal_q[2];
        assign operand4_o[l] = lane_scal_q[3];
    end
endmodule
